// File: rtl/addr_dec_pkg.sv
// addr_dec_pkg: shared types and defaults for the unit address decoder output stage.
package addr_dec_pkg;
   localparam int DEF_N_PORTS        = 6;
   localparam int DEF_ADDR_W         = 8;
   localparam int DEF_DATA_W         = 8;
   localparam int DEF_REGION_SIZE    = 32;
   localparam int DEF_TIMEOUT_CYCLES = 16;
   localparam int MAX_DATA_W         = 64;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} addr_dec_state_e;
   typedef struct packed {
      logic [MAX_DATA_W-1:0] rd_data;
      logic                  err;
   } addr_dec_resp_t;
   function automatic int port_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/addr_region_decode.sv
// addr_region_decode: maps an address to a slave port index, one-hot select and decode error.
module addr_region_decode
   import addr_dec_pkg::*;
#(
   parameter int N_PORTS     = DEF_N_PORTS,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int REGION_SIZE = DEF_REGION_SIZE,
   parameter int PW          = port_w(N_PORTS)
) (
   input  logic [ADDR_W-1:0]  addr,
   output logic [PW-1:0]      port,
   output logic [N_PORTS-1:0] sel,
   output logic               err
);
   logic [ADDR_W:0] idx;
   always_comb begin
      idx  = {1'b0, addr} / (ADDR_W+1)'(REGION_SIZE);
      err  = idx >= (ADDR_W+1)'(N_PORTS);
      port = PW'(idx);
      sel  = err ? '0 : N_PORTS'(1) << idx;
   end
endmodule

// File: rtl/addr_dec_out_ctrl.sv
// addr_dec_out_ctrl: one-transaction-at-a-time slave select/ack controller with buffered response.
// Optional ack timeout is enabled by defining ADDR_DEC_TIMEOUT_EN.
module addr_dec_out_ctrl
   import addr_dec_pkg::*;
#(
   parameter int N_PORTS        = DEF_N_PORTS,
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int REGION_SIZE    = DEF_REGION_SIZE,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               req_valid_in,
   output logic               req_ready_out,
   input  logic               req_wr_rd_s_in,
   input  logic [ADDR_W-1:0]  req_addr_in,
   input  logic [DATA_W-1:0]  req_wr_data_in,
   output logic               resp_valid_out,
   input  logic               resp_ready_in,
   output logic [DATA_W-1:0]  resp_rd_data_out,
   output logic               resp_err_out,
   output logic [N_PORTS-1:0] sel_en_out,
   output logic               wr_rd_s_out,
   output logic [ADDR_W-1:0]  addr_out,
   output logic [DATA_W-1:0]  wr_data_out,
   input  logic [DATA_W-1:0]  rd_data_in,
   input  logic [N_PORTS-1:0] ack_in
);
   localparam int PW = port_w(N_PORTS);
   if (N_PORTS < 1 || N_PORTS > 16 || DATA_W > MAX_DATA_W ||
       longint'(N_PORTS) * REGION_SIZE > (longint'(1) << ADDR_W)) begin : g_bad_cfg
      $error("addr_dec_out_ctrl: unsupported N_PORTS/REGION_SIZE/ADDR_W/DATA_W combination");
   end
   addr_dec_state_e      state;
   addr_dec_resp_t       resp_q;
   logic [PW-1:0]        port_q, dec_port;
   logic [N_PORTS-1:0]   dec_sel;
   logic                 dec_err, ack_hit, expired, unused_rd;
   addr_region_decode #(
      .N_PORTS(N_PORTS), .ADDR_W(ADDR_W), .REGION_SIZE(REGION_SIZE), .PW(PW)
   ) u_dec (
      .addr(req_addr_in), .port(dec_port), .sel(dec_sel), .err(dec_err)
   );
   // Only the selected slave's ack matters; others are ignored.
   assign ack_hit          = ack_in[port_q];
   assign req_ready_out    = state == IDLE && !reset;
   assign resp_valid_out   = state == RESP;
   assign resp_rd_data_out = resp_q.rd_data[DATA_W-1:0];
   assign resp_err_out     = resp_q.err;
   assign unused_rd        = ^resp_q.rd_data;
`ifdef ADDR_DEC_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt;
   assign expired = cnt == CW'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge clock or posedge reset) begin
      if (reset) cnt <= '0;
      else if (state != WAIT) cnt <= '0;
      else if (!ack_hit) cnt <= cnt + 1'b1;
   end
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;
   assign expired = 1'b0;
`endif
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         sel_en_out  <= '0;
         wr_rd_s_out <= 1'b0;
         addr_out    <= '0;
         wr_data_out <= '0;
         port_q      <= '0;
         resp_q      <= '0;
      end else begin
         case (state)
            IDLE: if (req_valid_in) begin
               wr_rd_s_out <= req_wr_rd_s_in;
               addr_out    <= req_addr_in;
               wr_data_out <= req_wr_data_in;
               port_q      <= dec_port;
               sel_en_out  <= dec_sel;
               resp_q      <= '{rd_data: '0, err: dec_err};
               state       <= dec_err ? RESP : WAIT;
            end
            WAIT: if (ack_hit || expired) begin
               sel_en_out     <= '0;
               resp_q.rd_data <= ack_hit && !wr_rd_s_out ? MAX_DATA_W'(rd_data_in) : '0;
               resp_q.err     <= !ack_hit;
               state          <= RESP;
            end
            RESP: if (resp_ready_in) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_addr_dec_out_ctrl.sv
// tb_addr_dec_out_ctrl: directed table, random transactions against a region model, reset and timeout sequences.
module tb_addr_dec_out_ctrl;
   localparam int NP = 6, AW = 8, DW = 8, RS = 32, TO = 16;
   logic          clock = 1'b0, reset = 1'b0;
   logic          req_valid_in = 1'b0, req_wr_rd_s_in = 1'b0, resp_ready_in = 1'b0;
   logic [AW-1:0] req_addr_in = '0;
   logic [DW-1:0] req_wr_data_in = '0, rd_data_in = '0;
   logic [NP-1:0] ack_in = '0;
   logic          req_ready_out, resp_valid_out, resp_err_out, wr_rd_s_out;
   logic [DW-1:0] resp_rd_data_out, wr_data_out;
   logic [NP-1:0] sel_en_out;
   logic [AW-1:0] addr_out;
   int n_chk = 0, n_pass = 0;
   always #5 clock = ~clock;
   addr_dec_out_ctrl #(.N_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .REGION_SIZE(RS), .TIMEOUT_CYCLES(TO)) dut (
      .clock(clock), .reset(reset), .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
      .req_wr_rd_s_in(req_wr_rd_s_in), .req_addr_in(req_addr_in), .req_wr_data_in(req_wr_data_in),
      .resp_valid_out(resp_valid_out), .resp_ready_in(resp_ready_in), .resp_rd_data_out(resp_rd_data_out),
      .resp_err_out(resp_err_out), .sel_en_out(sel_en_out), .wr_rd_s_out(wr_rd_s_out), .addr_out(addr_out),
      .wr_data_out(wr_data_out), .rd_data_in(rd_data_in), .ack_in(ack_in)
   );
   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd, rd;
      int            ncyc, hold;
      logic [NP-1:0] esel;
      logic [DW-1:0] erd;
      logic          eerr;
   } vec_t;
   vec_t tbl[7];
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask
   task automatic tick();
      @(posedge clock);
      #1;
   endtask
   function automatic void model(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] rd,
                                 output logic [NP-1:0] esel, output logic [DW-1:0] erd, output logic eerr);
      int p = int'(a) / RS;
      eerr = p >= NP;
      esel = eerr ? '0 : NP'(1 << p);
      erd  = (eerr || wr) ? '0 : rd;
   endfunction
   // ncyc = cycles select is seen high; ack is driven during the last of them
   task automatic txn(input string tag, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input logic [DW-1:0] rd, input int ncyc, input int hold,
                      input logic [NP-1:0] esel, input logic [DW-1:0] erd, input logic eerr);
      check({tag, ".ready_idle"}, 32'(req_ready_out), 1);
      req_valid_in = 1'b1; req_wr_rd_s_in = wr; req_addr_in = a; req_wr_data_in = wd;
      tick();
      req_valid_in = 1'b0; req_addr_in = 8'($urandom); req_wr_data_in = 8'($urandom);
      req_wr_rd_s_in = 1'($urandom);
      if (esel != '0) begin
         for (int i = 1; i <= ncyc; i++) begin
            check({tag, ".sel"}, 32'(sel_en_out), 32'(esel));
            check({tag, ".addr"}, 32'(addr_out), 32'(a));
            check({tag, ".dir"}, 32'(wr_rd_s_out), 32'(wr));
            if (wr) check({tag, ".wdata"}, 32'(wr_data_out), 32'(wd));
            check({tag, ".wait_valid"}, 32'(resp_valid_out), 0);
            check({tag, ".wait_ready"}, 32'(req_ready_out), 0);
            if (i == ncyc) begin ack_in = esel; rd_data_in = rd; end
            else if (i == 1) ack_in = ~esel;
            tick();
            ack_in = '0; rd_data_in = 8'($urandom);
         end
      end
      check({tag, ".sel_off"}, 32'(sel_en_out), 0);
      for (int i = 0; i <= hold; i++) begin
         if (i == hold) resp_ready_in = 1'b1;
         check({tag, ".valid"}, 32'(resp_valid_out), 1);
         check({tag, ".rd"}, 32'(resp_rd_data_out), 32'(erd));
         check({tag, ".err"}, 32'(resp_err_out), 32'(eerr));
         check({tag, ".resp_ready"}, 32'(req_ready_out), 0);
         tick();
      end
      resp_ready_in = 1'b0;
      check({tag, ".valid_done"}, 32'(resp_valid_out), 0);
      check({tag, ".ready_back"}, 32'(req_ready_out), 1);
   endtask
   initial begin
      logic [NP-1:0] esel;
      logic [DW-1:0] erd, rd, wd;
      logic [AW-1:0] a;
      logic          eerr, wr;
      tbl[0] = '{1'b0, 8'h45, 8'h00, 8'hA5, 3, 0, 6'b000100, 8'hA5, 1'b0};
      tbl[1] = '{1'b1, 8'hBF, 8'h3C, 8'h77, 1, 0, 6'b100000, 8'h00, 1'b0};
      tbl[2] = '{1'b0, 8'hC0, 8'h00, 8'h99, 0, 1, 6'b000000, 8'h00, 1'b1};
      tbl[3] = '{1'b0, 8'h9F, 8'h00, 8'h5E, 4, 5, 6'b010000, 8'h5E, 1'b0};
      tbl[4] = '{1'b0, 8'h00, 8'h00, 8'h11, 2, 0, 6'b000001, 8'h11, 1'b0};
      tbl[5] = '{1'b1, 8'hFF, 8'h12, 8'h34, 0, 0, 6'b000000, 8'h00, 1'b1};
      tbl[6] = '{1'b1, 8'h20, 8'hC3, 8'h88, 2, 2, 6'b000010, 8'h00, 1'b0};
      #1 reset = 1'b1;
      #1;
      check("rst.ready", 32'(req_ready_out), 0);
      check("rst.valid", 32'(resp_valid_out), 0);
      check("rst.sel", 32'(sel_en_out), 0);
      check("rst.err", 32'(resp_err_out), 0);
      check("rst.addr", 32'(addr_out), 0);
      tick(); tick();
      reset = 1'b0;
      #1 check("rst.ready_after", 32'(req_ready_out), 1);
      tick();
      for (int i = 0; i < 7; i++)
         txn($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].rd,
             tbl[i].ncyc, tbl[i].hold, tbl[i].esel, tbl[i].erd, tbl[i].eerr);
      for (int i = 0; i < 40; i++) begin
         wr = 1'($urandom); a = 8'($urandom); wd = 8'($urandom); rd = 8'($urandom);
         model(wr, a, rd, esel, erd, eerr);
         txn($sformatf("rnd%0d", i), wr, a, wd, rd, int'($urandom_range(1, 8)),
             int'($urandom_range(0, 3)), esel, erd, eerr);
      end
      req_valid_in = 1'b1; req_wr_rd_s_in = 1'b1; req_addr_in = 8'h45; req_wr_data_in = 8'hE7;
      tick();
      req_valid_in = 1'b0;
      tick();
      check("midrst.sel_before", 32'(sel_en_out), 32'(6'b000100));
      #2 reset = 1'b1;
      #1;
      check("midrst.sel", 32'(sel_en_out), 0);
      check("midrst.addr", 32'(addr_out), 0);
      check("midrst.wdata", 32'(wr_data_out), 0);
      check("midrst.dir", 32'(wr_rd_s_out), 0);
      check("midrst.ready", 32'(req_ready_out), 0);
      check("midrst.valid", 32'(resp_valid_out), 0);
      ack_in = 6'b000100;
      tick(); tick();
      ack_in = '0;
      reset = 1'b0;
      #1 check("midrst.ready_after", 32'(req_ready_out), 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("midrst.no_stale_valid", 32'(resp_valid_out), 0);
         check("midrst.no_sel", 32'(sel_en_out), 0);
      end
`ifdef ADDR_DEC_TIMEOUT_EN
      req_valid_in = 1'b1; req_wr_rd_s_in = 1'b0; req_addr_in = 8'h45;
      tick();
      req_valid_in = 1'b0;
      for (int i = 0; i < TO; i++) begin
         check("to.sel", 32'(sel_en_out), 32'(6'b000100));
         check("to.wait_valid", 32'(resp_valid_out), 0);
         tick();
      end
      check("to.sel_off", 32'(sel_en_out), 0);
      check("to.valid", 32'(resp_valid_out), 1);
      check("to.err", 32'(resp_err_out), 1);
      check("to.rd", 32'(resp_rd_data_out), 0);
      resp_ready_in = 1'b1;
      tick();
      resp_ready_in = 1'b0;
      check("to.valid_done", 32'(resp_valid_out), 0);
      txn("to_ack16", 1'b0, 8'h45, 8'h00, 8'h5A, TO, 0, 6'b000100, 8'h5A, 1'b0);
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
